// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input controller:
// PS/2 scan codes, control bundle layout and the coin sequencer states.
package arcade_input_pkg;

    localparam logic [7:0] PS2_RELEASE = 8'hF0;
    localparam logic [7:0] PS2_EXTEND  = 8'hE0;

    // Direction and bomb keys match on the low byte only (extended or not)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_BOMB  = 8'h14;

    localparam logic [8:0] KEY_FIRE   = 9'h029;
    localparam logic [8:0] KEY_START1 = 9'h005;
    localparam logic [8:0] KEY_START2 = 9'h006;

    typedef struct packed {
        logic start2;
        logic start1;
        logic bomb;
        logic fire;
        logic right;
        logic left;
        logic down;
        logic up;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

endpackage

// File: rtl/arcade_input_ctrl_coin_pulser.sv
// Coin pulse sequencer: queues up to three coin requests and emits
// fixed-width coin pulses separated by a minimum low time.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int COIN_LEN = 18432,
    parameter int COIN_GAP = 36864
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req,
    output logic coin,
    output logic busy
);

    localparam int CNT_MAX = (COIN_LEN > COIN_GAP) ? COIN_LEN : COIN_GAP;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LEN_LOAD = CNT_W'(COIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(COIN_GAP - 1);

    coin_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       pending, pending_next;
    logic             coin_next, busy_next, launch;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            coin    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
            coin    <= coin_next;
            busy    <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if ((pending != '0) || req) begin
                    state_next = PULSE;
                    cnt_next   = LEN_LOAD;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A request arriving on the launch edge is consumed by that launch
    always_comb begin
        launch       = (state == IDLE) && ((pending != '0) || req);
        pending_next = pending;
        if (launch) begin
            if (!req) begin
                pending_next = pending - 1'b1;
            end
        end else if (req && (pending != 2'd3)) begin
            pending_next = pending + 1'b1;
        end
        coin_next = (state_next == PULSE);
        busy_next = (state_next != IDLE) || (pending_next != '0);
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade control front end: merges PS/2 keys and joystick, applies the
// rotation remap, and generates coin pulses on start presses.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int COIN_LEN = 18432,
    parameter int COIN_GAP = 36864
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        fire,
    output logic        bomb,
    output logic        start1,
    output logic        start2,
    output logic        coin,
    output logic        coin_busy
);

    logic       toggle_q, key_event, pressed, extended;
    logic [8:0] code;
    ctrl_t      key_q, raw, ctrl_next, ctrl_q;
    logic       start_prev, coin_req;
    logic       unused_joy;

    assign unused_joy = ^joy[15:8];
    assign key_event  = ps2_key[64] ^ toggle_q;

    always_comb begin
        pressed  = (ps2_key[15:8] != PS2_RELEASE);
        extended = pressed ? (ps2_key[15:8] == PS2_EXTEND)
                           : (ps2_key[23:16] == PS2_EXTEND);
        code     = {extended, ps2_key[7:0]};
        if (ps2_key[63:24] != '0) begin
            code = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
            key_q    <= '0;
        end else begin
            toggle_q <= ps2_key[64];
            if (key_event) begin
                case (code[7:0])
                    SC_UP:    key_q.up    <= pressed;
                    SC_DOWN:  key_q.down  <= pressed;
                    SC_LEFT:  key_q.left  <= pressed;
                    SC_RIGHT: key_q.right <= pressed;
                    SC_BOMB:  key_q.bomb  <= pressed;
                    default: ;
                endcase
                case (code)
                    KEY_FIRE:   key_q.fire   <= pressed;
                    KEY_START1: key_q.start1 <= pressed;
                    KEY_START2: key_q.start2 <= pressed;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        raw.up     = key_q.up     | joy[3];
        raw.down   = key_q.down   | joy[2];
        raw.left   = key_q.left   | joy[1];
        raw.right  = key_q.right  | joy[0];
        raw.fire   = key_q.fire   | joy[4];
        raw.bomb   = key_q.bomb   | joy[5];
        raw.start1 = key_q.start1 | joy[6];
        raw.start2 = key_q.start2 | joy[7];
        ctrl_next  = raw;
        if (rotate) begin
            ctrl_next.up    = raw.left;
            ctrl_next.down  = raw.right;
            ctrl_next.left  = raw.down;
            ctrl_next.right = raw.up;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            start_prev <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_next;
            start_prev <= ctrl_q.start1 | ctrl_q.start2;
        end
    end

    assign coin_req = (ctrl_q.start1 | ctrl_q.start2) & ~start_prev;

    assign up     = ctrl_q.up;
    assign down   = ctrl_q.down;
    assign left   = ctrl_q.left;
    assign right  = ctrl_q.right;
    assign fire   = ctrl_q.fire;
    assign bomb   = ctrl_q.bomb;
    assign start1 = ctrl_q.start1;
    assign start2 = ctrl_q.start2;

    coin_pulser #(
        .COIN_LEN(COIN_LEN),
        .COIN_GAP(COIN_GAP)
    ) u_coin (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .req    (coin_req),
        .coin   (coin),
        .busy   (coin_busy)
    );

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with short coin timing (4 on / 8 gap).
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [64:0] ps2_key;
    logic [15:0] joy;
    logic        rotate;
    logic        up, down, left, right, fire, bomb, start1, start2, coin, coin_busy;
    logic        tgl;
    int          tests = 0;
    int          fails = 0;

    logic [7:0] ctl;
    assign ctl = {start2, start1, bomb, fire, right, left, down, up};

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(
        .COIN_LEN(4),
        .COIN_GAP(8)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_key  (ps2_key),
        .joy      (joy),
        .rotate   (rotate),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .fire     (fire),
        .bomb     (bomb),
        .start1   (start1),
        .start2   (start2),
        .coin     (coin),
        .coin_busy(coin_busy)
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic [39:0] hi, input logic [23:0] lo);
        tgl     = ~tgl;
        ps2_key = {tgl, hi, lo};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ps2_key = '0;
        joy     = '0;
        rotate  = 1'b0;
        tgl     = 1'b0;
        #3;
        tests++;
        if ({ctl, coin, coin_busy} !== 10'h000) begin
            $display("FAIL reset_outputs got=%h want=000", {ctl, coin, coin_busy});
            fails++;
        end
        // toggle already high while held in reset: first cycle after release is an event
        tgl     = 1'b1;
        ps2_key = {1'b1, 40'h0, 24'h000075};
        step();
        step();
        reset_n = 1'b1;
        step();
        tests++;
        if (ctl !== 8'h00) begin
            $display("FAIL reset_first_edge got=%h want=00", ctl);
            fails++;
        end
        step();
        tests++;
        if (ctl !== 8'h01) begin
            $display("FAIL reset_release_event got=%h want=01", ctl);
            fails++;
        end
        send_key(40'h0, 24'h00F075);
        step();
        step();
        tests++;
        if (ctl !== 8'h00) begin
            $display("FAIL reset_key_release got=%h want=00", ctl);
            fails++;
        end
    endtask

    task automatic test_keyboard();
        logic [7:0] sc [6];
        logic [7:0] bit_exp [6];
        sc      = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14};
        bit_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
        for (int i = 0; i < 6; i++) begin
            send_key(40'h0, {16'h0000, sc[i]});
            step();
            tests++;
            if (ctl !== 8'h00) begin
                $display("FAIL key_latency[%0d] got=%h want=00", i, ctl);
                fails++;
            end
            step();
            tests++;
            if (ctl !== bit_exp[i]) begin
                $display("FAIL key_press[%0d] got=%h want=%h", i, ctl, bit_exp[i]);
                fails++;
            end
            send_key(40'h0, {16'h00F0, sc[i]});
            step();
            step();
            tests++;
            if (ctl !== 8'h00) begin
                $display("FAIL key_release[%0d] got=%h want=00", i, ctl);
                fails++;
            end
        end
    endtask

    task automatic test_extended_and_filter();
        send_key(40'h0, 24'h00E075);
        step();
        step();
        tests++;
        if (ctl !== 8'h01) begin
            $display("FAIL ext_up_press got=%h want=01", ctl);
            fails++;
        end
        send_key(40'h0, 24'hE0F075);
        step();
        step();
        tests++;
        if (ctl !== 8'h00) begin
            $display("FAIL ext_up_release got=%h want=00", ctl);
            fails++;
        end
        send_key(40'h0, 24'h00E029);
        step();
        step();
        tests++;
        if (ctl !== 8'h00) begin
            $display("FAIL ext_fire_unmapped got=%h want=00", ctl);
            fails++;
        end
        send_key(40'h00_0000_0012, 24'h000029);
        step();
        step();
        tests++;
        if (ctl !== 8'h00) begin
            $display("FAIL filter_fire_press got=%h want=00", ctl);
            fails++;
        end
        send_key(40'h0, 24'h000029);
        step();
        step();
        send_key(40'h00_0000_0012, 24'h00F029);
        step();
        step();
        tests++;
        if (ctl !== 8'h10) begin
            $display("FAIL filter_fire_release got=%h want=10", ctl);
            fails++;
        end
        send_key(40'h0, 24'h00F029);
        step();
        step();
        tests++;
        if (ctl !== 8'h00) begin
            $display("FAIL fire_release got=%h want=00", ctl);
            fails++;
        end
    endtask

    task automatic test_rotate();
        logic [15:0] jv [5];
        logic        rv [5];
        logic [7:0]  ev [5];
        jv = '{16'h0008, 16'h0008, 16'h0002, 16'h0001, 16'h0014};
        rv = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b1};
        ev = '{8'h08,    8'h01,    8'h01,    8'h02,    8'h14};
        for (int i = 0; i < 5; i++) begin
            joy    = jv[i];
            rotate = rv[i];
            step();
            tests++;
            if (ctl !== ev[i]) begin
                $display("FAIL rotate[%0d] joy=%h rot=%b got=%h want=%h", i, jv[i], rv[i], ctl, ev[i]);
                fails++;
            end
        end
        joy    = '0;
        rotate = 1'b0;
        step();
        tests++;
        if (ctl !== 8'h00) begin
            $display("FAIL rotate_clear got=%h want=00", ctl);
            fails++;
        end
    endtask

    task automatic test_coin_single();
        int hi;
        int gap;
        int extra;
        logic prev;
        joy = 16'h0040;
        step();
        joy = '0;
        for (int i = 0; i < 20 && !coin; i++) step();
        tests++;
        if (coin !== 1'b1) begin
            $display("FAIL coin_start got=%b want=1", coin);
            fails++;
        end
        hi = 0;
        while (coin === 1'b1 && hi < 50) begin
            hi++;
            step();
        end
        tests++;
        if (hi != 4) begin
            $display("FAIL coin_width got=%0d want=4", hi);
            fails++;
        end
        gap = 0;
        while (coin_busy === 1'b1 && gap < 50) begin
            gap++;
            step();
        end
        tests++;
        if (gap != 8) begin
            $display("FAIL coin_busy_tail got=%0d want=8", gap);
            fails++;
        end
        extra = 0;
        prev  = coin;
        for (int i = 0; i < 30; i++) begin
            step();
            if (coin && !prev) extra++;
            prev = coin;
        end
        tests++;
        if (extra != 0 || coin_busy !== 1'b0) begin
            $display("FAIL coin_single_quiet got=%0d/%b want=0/0", extra, coin_busy);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        int rise_t [$];
        int t;
        logic prev;
        // one launching edge, then five more while busy: three queue, two drop
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    joy = 16'h0040;
                    step();
                    joy = '0;
                    step();
                end
            end
            begin
                prev = coin;
                for (t = 0; t < 120; t++) begin
                    step();
                    if (coin && !prev) rise_t.push_back(t);
                    prev = coin;
                end
            end
        join
        tests++;
        if (rise_t.size() != 4) begin
            $display("FAIL b2b_pulse_count got=%0d want=4", rise_t.size());
            fails++;
        end
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (i >= rise_t.size()) begin
                $display("FAIL b2b_spacing[%0d] got=missing want=13", i);
                fails++;
            end else if (rise_t[i] - rise_t[i-1] != 13) begin
                $display("FAIL b2b_spacing[%0d] got=%0d want=13", i, rise_t[i] - rise_t[i-1]);
                fails++;
            end
        end
        tests++;
        if (coin_busy !== 1'b0) begin
            $display("FAIL b2b_idle got=%b want=0", coin_busy);
            fails++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        int rises;
        logic prev;
        ps2_key = '0;
        tgl     = 1'b0;
        // four edges: first launches, three queue; second pulse leaves two pending
        for (int i = 0; i < 4; i++) begin
            joy = 16'h0040;
            step();
            joy = '0;
            step();
        end
        rises = 0;
        prev  = coin;
        for (int i = 0; i < 40 && rises == 0; i++) begin
            step();
            if (coin && !prev) rises++;
            prev = coin;
        end
        tests++;
        if (rises != 1) begin
            $display("FAIL mid_second_pulse got=%0d want=1", rises);
            fails++;
        end
        step();
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (coin !== 1'b0 || coin_busy !== 1'b0) begin
            $display("FAIL mid_async_reset coin=%b busy=%b want=0/0", coin, coin_busy);
            fails++;
        end
        step();
        step();
        reset_n = 1'b1;
        rises = 0;
        prev  = coin;
        for (int i = 0; i < 60; i++) begin
            step();
            if (coin && !prev) rises++;
            prev = coin;
        end
        tests++;
        if (rises != 0 || coin_busy !== 1'b0) begin
            $display("FAIL mid_no_replay rises=%0d busy=%b want=0/0", rises, coin_busy);
            fails++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_keyboard();
        test_extended_and_filter();
        test_rotate();
        test_coin_single();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
